// File: rtl/uart_pkg.sv
// Shared UART definitions: oversample ratio, receiver/transmitter state
// encoding and the baud divider calculation.
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Clocks per oversample tick, truncated, never below one.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * OVERSAMPLE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO; a push while full is dropped
// unless a pop happens in the same cycle, and the drop is flagged for one cycle.
module sync_fifo #(
    parameter int width = 8,
    parameter int depth = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [width-1:0]         i_data,
    input  logic                     i_pop,
    output logic [width-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(depth):0]   o_level,
    output logic                     o_overrun
);

    localparam int AW = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [$clog2(depth):0] FULL_CNT = ($clog2(depth)+1)'(depth);

    logic [width-1:0]       r_mem [depth];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [$clog2(depth):0] r_count;
    logic                   r_overrun;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

    // Pointers are log2(depth) wide, so they wrap modulo depth on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_push && !w_do_push;
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data    = r_mem[r_rd_ptr];
    assign o_valid   = !w_empty;
    assign o_level   = r_count;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_rx_fifo.sv
// 16x-oversampled 8N1 UART receiver feeding a fall-through receive FIFO,
// with one-cycle frame-error and overrun pulses.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int clk_freq       = 100000000,
    parameter int uart_baud_rate = 115200,
    parameter int fifo_depth     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(fifo_depth):0]   fifo_level
);

    localparam int DIV = calc_div(clk_freq, uart_baud_rate);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [1:0]    r_sync;
    logic [1:0]    r_fill;
    logic          r_armed;
    logic [2:0]    r_state;
    logic [DW-1:0] r_div_cnt;
    logic [3:0]    r_tick_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_frame_err;

    logic          w_rxd;
    logic          w_tick;
    logic          w_centre;
    logic          w_push;
    logic [7:0]    w_fifo_data;
    logic          w_fifo_valid;
    logic          w_fifo_ovr;
    logic [$clog2(fifo_depth):0] w_fifo_level;

    assign w_rxd    = r_sync[1];
    assign w_tick   = (r_div_cnt == DIV_LAST);
    assign w_centre = w_tick && (r_tick_cnt ==
                      ((r_state == ST_START) ? 4'd7 : 4'(OVERSAMPLE - 1)));
    assign w_push   = (r_state == ST_STOP) && w_centre && w_rxd;

    // r_armed needs the real line seen high after reset, so a frame cut by
    // reset is not picked up mid-way: only a fresh 1->0 edge starts decoding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync      <= 2'b11;
            r_fill      <= 2'b00;
            r_armed     <= 1'b0;
            r_state     <= ST_IDLE;
            r_div_cnt   <= '0;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], uart_rxd};
            r_fill      <= {r_fill[0], 1'b1};
            r_frame_err <= 1'b0;
            if (r_fill[1] && w_rxd)
                r_armed <= 1'b1;

            if (r_state == ST_IDLE)
                r_div_cnt <= '0;
            else
                r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;

            if (r_state == ST_IDLE)
                r_tick_cnt <= '0;
            else if (w_tick)
                r_tick_cnt <= w_centre ? 4'd0 : r_tick_cnt + 4'd1;

            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt <= '0;
                    if (r_armed && !w_rxd)
                        r_state <= ST_START;
                end
                ST_START: begin
                    if (w_centre)
                        r_state <= w_rxd ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (w_centre) begin
                        r_shift   <= {w_rxd, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7)
                            r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_centre) begin
                        if (w_rxd) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    if (w_rxd)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .width (8),
        .depth (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_data    (r_shift),
        .i_pop     (rx_ready),
        .o_data    (w_fifo_data),
        .o_valid   (w_fifo_valid),
        .o_level   (w_fifo_level),
        .o_overrun (w_fifo_ovr)
    );

    // Outputs read as zero whenever reset is high, including its first cycle.
    assign rx_valid   = w_fifo_valid && !rst;
    assign rx_data    = rx_valid ? w_fifo_data : 8'h00;
    assign fifo_level = rst ? '0 : w_fifo_level;
    assign frame_err  = r_frame_err && !rst;
    assign overrun    = w_fifo_ovr && !rst;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: 80 clocks per bit, queue-based model of the
// receive FIFO, table vectors, directed corner sequences and random frames.
module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 100000000;
    localparam int BAUD     = 1152000;
    localparam int DEPTH    = 8;
    localparam int BITCLK   = 80;

    logic       clk = 1'b0;
    logic       rst;
    logic       uart_rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic [3:0] fifo_level;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .clk_freq       (CLK_FREQ),
        .uart_baud_rate (BAUD),
        .fifo_depth     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rxd   (uart_rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_level (fifo_level)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    int exp_ferr = 0;
    int exp_ovr  = 0;
    int pop_cnt  = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard: every pop must match the model queue head; pulses must be single-cycle.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_ferr = 1'b0;
    logic       prev_ovr  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
            prev_ferr = 1'b0;
            prev_ovr  = 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got byte 0x%0h, model queue empty", rx_data);
                end else begin
                    check("pop_data", int'(rx_data), int'(exp_q.pop_front()));
                end
            end
            if (prev_hold && rx_valid)
                check("hold_stable", int'(rx_data), int'(prev_data));
            prev_hold = rx_valid && !rx_ready;
            prev_data = rx_data;
            if (frame_err) begin
                ferr_cnt++;
                check("ferr_width", int'(prev_ferr), 0);
            end
            prev_ferr = frame_err;
            if (overrun) begin
                ovr_cnt++;
                check("ovr_width", int'(prev_ovr), 0);
            end
            prev_ovr = overrun;
        end
    end

    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line(input logic v, input int n);
        uart_rxd = v;
        clocks(n);
    endtask

    task automatic model_push(input logic [7:0] d);
        if (exp_q.size() < DEPTH)
            exp_q.push_back(d);
        else
            exp_ovr++;
    endtask

    // Start, 8 data bits LSB first, stop; the model is updated as the stop bit begins.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        line(1'b0, BITCLK);
        for (int i = 0; i < 8; i++)
            line(d[i], BITCLK);
        if (stop)
            model_push(d);
        else
            exp_ferr++;
        line(stop, BITCLK);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_pops;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, f0, o0;
        logic [7:0] d;
        logic       s;

        vecs[0] = '{8'h55, 1'b1, 1, 0};
        vecs[1] = '{8'hA3, 1'b1, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 0};
        vecs[4] = '{8'h81, 1'b0, 0, 1};
        vecs[5] = '{8'h7E, 1'b1, 1, 0};

        rst      = 1'b1;
        uart_rxd = 1'b1;
        rx_ready = 1'b0;
        clocks(3);
        check("rst_rx_valid",   int'(rx_valid),   0);
        check("rst_fifo_level", int'(fifo_level), 0);
        check("rst_frame_err",  int'(frame_err),  0);
        check("rst_overrun",    int'(overrun),    0);
        check("rst_rx_data",    int'(rx_data),    0);
        rst = 1'b0;
        clocks(10);
        rx_ready = 1'b1;

        for (int v = 0; v < 6; v++) begin
            p0 = pop_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop);
            line(1'b1, BITCLK);
            check($sformatf("vec%0d_pops", v), pop_cnt - p0, vecs[v].exp_pops);
            check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_level", v), int'(fifo_level), 0);
        end

        // Short low glitch is rejected at the start-bit centre.
        p0 = pop_cnt;
        f0 = ferr_cnt;
        line(1'b0, 20);
        line(1'b1, 200);
        check("glitch_pops", pop_cnt - p0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        send_frame(8'hA3, 1'b1);
        line(1'b1, BITCLK);
        check("post_glitch_pops", pop_cnt - p0, 1);

        // Bad stop bit followed by a held-low line.
        p0 = pop_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA3, 1'b0);
        line(1'b0, 200);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_level", int'(fifo_level), 0);
        check("break_pops", pop_cnt - p0, 0);
        line(1'b1, BITCLK);
        send_frame(8'h5A, 1'b1);
        line(1'b1, BITCLK);
        check("post_break_pops", pop_cnt - p0, 1);
        check("post_break_ferr", ferr_cnt - f0, 1);

        // Fill the FIFO with the consumer stalled, then overflow by one.
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        for (int b = 0; b < 9; b++) begin
            if (b == 8)
                check("ovr_before_last", ovr_cnt - o0, 0);
            send_frame(8'(b), 1'b1);
            line(1'b1, BITCLK);
        end
        check("full_level", int'(fifo_level), DEPTH);
        check("full_ovr", ovr_cnt - o0, 1);
        check("full_valid", int'(rx_valid), 1);
        check("full_head", int'(rx_data), 0);
        rx_ready = 1'b1;
        clocks(20);
        check("drain_level", int'(fifo_level), 0);
        check("drain_model", exp_q.size(), 0);

        // Reset in the middle of bit 3 of a 0xF0 frame while a byte is queued.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        line(1'b1, BITCLK);
        check("prerst_level", int'(fifo_level), 1);
        line(1'b0, 4 * BITCLK);
        line(1'b0, BITCLK / 2);
        rst = 1'b1;
        clocks(1);
        rst = 1'b0;
        exp_q.delete();
        check("midrst_valid", int'(rx_valid), 0);
        check("midrst_level", int'(fifo_level), 0);
        rx_ready = 1'b1;
        p0 = pop_cnt;
        f0 = ferr_cnt;
        line(1'b0, BITCLK / 2);
        line(1'b1, 6 * BITCLK);
        check("aborted_pops", pop_cnt - p0, 0);
        check("aborted_ferr", ferr_cnt - f0, 0);
        send_frame(8'h3C, 1'b1);
        line(1'b1, BITCLK);
        check("post_rst_pops", pop_cnt - p0, 1);
        check("post_rst_level", int'(fifo_level), 0);

        // Random frames, mostly good stop bits.
        for (int r = 0; r < 10; r++) begin
            d = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 4) != 0);
            send_frame(d, s);
            line(1'b1, $urandom_range(BITCLK, 200));
        end

        check("total_ferr", ferr_cnt, exp_ferr);
        check("total_ovr", ovr_cnt, exp_ovr);
        check("final_model_empty", exp_q.size(), 0);
        check("final_valid", int'(rx_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter clk_freq, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter uart_baud_rate, default 115200, serial bit rate.
REQ-003 SHALL have parameter fifo_depth, default 8, receive FIFO entries; power of two, 2..64.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port uart_rxd  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data  output  8  FIFO head byte, valid only while rx_valid=1.
REQ-008 SHALL have port rx_valid  output  1  FIFO not empty.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts head byte.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a received byte is dropped because the FIFO is full.
REQ-012 SHALL have port fifo_level  output  clog2(fifo_depth)+1  current occupancy.

Function
REQ-013 SHALL pass uart_rxd through a 2-flop synchronizer; all decoding uses the synchronized value (2-cycle input latency).
REQ-014 SHALL generate a 16x oversample tick every DIV = max(1, clk_freq/(uart_baud_rate*16)) clocks, using integer truncation.
REQ-015 SHALL use receiver states IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE: synchronized line = 0 -> START; tick phase counter cleared.
REQ-017 START: at tick 8 (bit centre), line = 0 -> DATA; line = 1 -> IDLE (glitch rejected, nothing pushed, no error).
REQ-018 DATA: sample every 16 ticks at bit centre; 8 bits, LSB first, shifted into an 8-bit register; after bit 7 -> STOP.
REQ-019 STOP: centre sample = 1 -> push byte into FIFO, then IDLE; sample = 0 -> frame_err pulse, byte discarded, then BREAK.
REQ-020 BREAK: wait for synchronized line = 1, then IDLE.
REQ-021 Pushed byte SHALL appear at rx_data/rx_valid on the cycle after the stop-bit centre sample when the FIFO was empty (first-word fall-through).
REQ-022 Handshake: pop occurs on rising edge where rx_valid=1 and rx_ready=1; rx_data is stable while rx_valid=1 and rx_ready=0.
REQ-023 Push to a full FIFO without a simultaneous pop SHALL drop the byte, pulse overrun, and leave FIFO contents unchanged.
REQ-024 Push and pop in the same cycle when full SHALL both succeed; level is unchanged and overrun stays 0.
REQ-025 Push and pop in the same cycle when empty: push only; rx_valid rises next cycle.
REQ-026 Read and write pointers SHALL wrap modulo fifo_depth; level SHALL saturate neither below 0 nor above fifo_depth.
REQ-027 frame_err and overrun SHALL never be asserted for more than one cycle per event.

Reset
REQ-028 While rst=1: state IDLE, synchronizer flops = 1, tick and bit counters 0, FIFO emptied.
REQ-029 Output values while rst=1: rx_valid=0, fifo_level=0, frame_err=0, overrun=0, rx_data=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; after release, the receiver SHALL not decode until a new 1->0 start edge occurs.

Structure
REQ-031 SHALL place the state encoding and OVERSAMPLE=16 in shared package uart_pkg, reused by the matching transmitter.
REQ-032 SHALL implement the FIFO as sub-module sync_fifo (parameters width=8, depth=fifo_depth).

Verification (clk_freq=100000000, uart_baud_rate=1152000 -> DIV=5, 80 clocks/bit)
REQ-033 Send 0x55, stop=1, rx_ready=1 -> exactly one rx_valid cycle with rx_data=0x55; frame_err=0.
REQ-034 Drive uart_rxd low for 20 clocks, then high -> no push, no frame_err; the next 0xA3 frame is received as 0xA3.
REQ-035 Send 0xA3 with stop=0, then hold the line low for 200 clocks -> one frame_err pulse; fifo_level=0; no decode until the line returns high.
REQ-036 rx_ready=0, send 0x00..0x08 -> fifo_level=8, one overrun pulse on 0x08; popping yields 0x00..0x07 in order.
REQ-037 Assert rst for 1 cycle during bit 3 of a frame -> rx_valid=0, fifo_level=0; the following 0x3C frame is received correctly.
